// File: rtl/riscv_pkg.sv
// Shared load/store encodings, FSM state and lane helpers for the data memory unit.
package riscv_pkg;

  localparam int BYTE_LANES = 4;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, RESP, WDONE} dmem_state_e;

  typedef struct packed {
    logic [2:0] size;
    logic [1:0] lane;
    logic       fault;
  } dmem_req_t;

  function automatic logic is_byte(input logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] sz);
    return (sz == SZ_H) || (sz == SZ_HU);
  endfunction

  // Undefined size codes fall through to word behaviour everywhere.
  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] a);
    if (is_byte(sz)) return 1'b0;
    if (is_half(sz)) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [1:0] align_lane(input logic [2:0] sz, input logic [1:0] a);
    if (is_byte(sz)) return a;
    if (is_half(sz)) return {a[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic logic [BYTE_LANES-1:0] byte_en(input logic [2:0] sz, input logic [1:0] lane);
    if (is_byte(sz)) return 4'b0001 << lane;
    if (is_half(sz)) return lane[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word SRAM, one storage column per byte lane, byte-enabled write, registered read.
module dmem_sram
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rd_en,
  input  logic [BYTE_LANES-1:0]          wr_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_be[l]) mem[idx] <= wdata[8*l +: 8];
      if (rd_en)    rd_q     <= mem[idx];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store data memory unit: IDLE/READ/RESP/WDONE FSM in front of dmem_sram.
// Compile option: DMEM_MISALIGN_TRAP_EN traps misaligned H/HU/W accesses instead of aligning them.
module data_mem_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_read_en,
  input  logic        data_write_en,
  input  logic [2:0]  data_size,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        misalign_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e           state, state_nxt;
  dmem_req_t             req_in, req_q;
  logic [AW-1:0]         idx_in, idx_q, sram_idx;
  logic [BYTE_LANES-1:0] wr_be;
  logic [31:0]           wdata_rep, sram_rdata, load_val, hold_q;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  accept_wr, accept_rd;
  logic                  unused_addr_hi;

  assign idx_in         = addr[AW+1:2];
  assign unused_addr_hi = &{1'b0, addr[31:AW+2]};
  assign req_in.size    = data_size;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_in.lane  = addr[1:0];
  assign req_in.fault = misaligned(data_size, addr[1:0]);
`else
  assign req_in.lane  = align_lane(data_size, addr[1:0]);
  assign req_in.fault = 1'b0;
`endif

  // Write wins when both enables are high.
  assign accept_wr = (state == IDLE) && data_write_en;
  assign accept_rd = (state == IDLE) && data_read_en && !data_write_en;

  // rst_n gates the write so an edge taken during reset cannot commit.
  assign wr_be    = (accept_wr && rst_n && !req_in.fault) ? byte_en(data_size, req_in.lane) : '0;
  assign sram_idx = (state == IDLE) ? idx_in : idx_q;

  always_comb begin
    wdata_rep = write_data;
    if (is_byte(data_size))      wdata_rep = {4{write_data[7:0]}};
    else if (is_half(data_size)) wdata_rep = {2{write_data[15:0]}};
  end

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .rd_en (state == READ),
    .wr_be (wr_be),
    .idx   (sram_idx),
    .wdata (wdata_rep),
    .rdata (sram_rdata)
  );

  always_comb begin
    byte_sel = sram_rdata[{req_q.lane, 3'b000} +: 8];
    half_sel = req_q.lane[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    load_val = sram_rdata;
    case (req_q.size)
      SZ_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_val = {24'h0, byte_sel};
      SZ_H:    load_val = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   load_val = {16'h0, half_sel};
      default: load_val = sram_rdata;
    endcase
    if (req_q.fault) load_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= '0;
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept_wr || accept_rd) begin
        req_q <= req_in;
        idx_q <= idx_in;
      end
      if (state == RESP) hold_q <= load_val;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    read_data = hold_q;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept_wr)      state_nxt = WDONE;
        else if (accept_rd) state_nxt = READ;
      end
      READ:  state_nxt = RESP;
      RESP: begin
        done      = 1'b1;
        read_data = load_val;
        state_nxt = IDLE;
      end
      WDONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_fault = done && req_q.fault;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule
